// File: rtl/sclk_pkg.sv
// Shared types and widths for the SCLK divider.
package sclk_pkg;

    localparam int unsigned SCLK_CNT_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sclk_state_t;

endpackage

// File: rtl/sclk_divider_if.sv
// Divider bus: maxcount in, SCLK/ACTIVE out. SCLK_TICK exists only with `SCLK_TICK_EN.
interface sclk_divider_if #(
    parameter int unsigned CNT_W = sclk_pkg::SCLK_CNT_W
);
    logic [CNT_W-1:0] maxcount;
    logic             SCLK;
    logic             ACTIVE;
`ifdef SCLK_TICK_EN
    logic             SCLK_TICK;
`endif

    modport master (
        output maxcount,
        input  SCLK,
        input  ACTIVE
`ifdef SCLK_TICK_EN
        , input SCLK_TICK
`endif
    );

    modport slave (
        input  maxcount,
        output SCLK,
        output ACTIVE
`ifdef SCLK_TICK_EN
        , output SCLK_TICK
`endif
    );

endinterface

// File: rtl/sclk_divider.sv
// Divides CLK into SCLK = f_CLK / (2*(maxcount+1)); maxcount==0 silences it.
// `SCLK_TICK_EN adds a one-cycle SCLK_TICK pulse on every SCLK rise.
module sclk_divider
    import sclk_pkg::*;
#(
    parameter int unsigned CNT_W = SCLK_CNT_W
) (
    input  logic           CLK,
    input  logic           RST,
    sclk_divider_if.slave  bus
);

    sclk_state_t      r_state;
    sclk_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_max;
    logic [CNT_W-1:0] w_max_nxt;
    logic             r_sclk;
    logic             w_sclk_nxt;
    logic             r_active;
    logic             w_terminal;
    logic             w_mc_zero;
`ifdef SCLK_TICK_EN
    logic             r_tick;
`endif

    assign w_terminal = (r_cnt == r_max);
    assign w_mc_zero  = (bus.maxcount == '0);

    // State, counter, shadow register and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_max    <= '0;
            r_sclk   <= 1'b0;
            r_active <= 1'b0;
`ifdef SCLK_TICK_EN
            r_tick   <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_max    <= w_max_nxt;
            r_sclk   <= w_sclk_nxt;
            r_active <= (w_state_nxt == RUN);
`ifdef SCLK_TICK_EN
            r_tick   <= w_sclk_nxt & ~r_sclk;
`endif
        end
    end

    // Next state: leave IDLE on nonzero maxcount, return only at a terminal count
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (!w_mc_zero) w_state_nxt = RUN;
            RUN:     if (w_terminal && w_mc_zero) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath/output next values; maxcount is only sampled on entry and at terminal counts
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_max_nxt  = r_max;
        w_sclk_nxt = r_sclk;
        case (r_state)
            IDLE: begin
                w_cnt_nxt  = '0;
                w_sclk_nxt = 1'b0;
                if (!w_mc_zero) w_max_nxt = bus.maxcount;
            end
            RUN: begin
                if (w_terminal) begin
                    w_cnt_nxt  = '0;
                    w_max_nxt  = bus.maxcount;
                    w_sclk_nxt = w_mc_zero ? 1'b0 : ~r_sclk;
                end else begin
                    w_cnt_nxt  = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_cnt_nxt  = '0;
                w_sclk_nxt = 1'b0;
            end
        endcase
    end

    assign bus.SCLK   = r_sclk;
    assign bus.ACTIVE = r_active;
`ifdef SCLK_TICK_EN
    assign bus.SCLK_TICK = r_tick;
`endif

endmodule
